pll_cfg_ctrl: RTL and testbench

Synchronous configuration sequencer on the driving side of the `tech_pll` macro. It accepts a new divider set over a valid/ready handshake and validates it. It then holds the downstream clock mux in bypass while the dividers change, and waits for a synchronized, debounced lock with a timeout. It also monitors lock loss while running. It sits in the clock/reset subsystem between the control-register block and the PLL, clocked by the reference clock.

---
 rtl/pll_cfg_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pll_cfg_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: configuration sequencer driving the tech_pll divider inputs.
// Accepts a divider set over valid/ready and rejects illegal sets. Holds the
// downstream clock mux in bypass while the dividers change. Waits for a
// synchronized, debounced lock (with timeout) and watches for lock loss.
module pll_cfg_ctrl #(
    parameter logic [5:0]  DEF_REFDIV   = 6'd1,
    parameter logic [11:0] DEF_FBDIV    = 12'd16,
    parameter logic [2:0]  DEF_POSTDIV1 = 3'd1,
    parameter logic [2:0]  DEF_POSTDIV2 = 3'd1,
    parameter int unsigned BYPASS_CYC   = 4,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [5:0]  cfg_refdiv_i,
    input  logic [11:0] cfg_fbdiv_i,
    input  logic [2:0]  cfg_postdiv1_i,
    input  logic [2:0]  cfg_postdiv2_i,
    output logic [5:0]  refdiv_o,
    output logic [11:0] fbdiv_o,
    output logic [2:0]  postdiv1_o,
    output logic [2:0]  postdiv2_o,
    input  logic        pll_lock_i,
    output logic        bypass_o,
    output logic        locked_o,
    output logic        err_cfg_o,
    output logic        timeout_o,
    output logic        lock_lost_o
);

    localparam int BW = $clog2(BYPASS_CYC + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [BW-1:0] BYP_MAX  = BW'(BYPASS_CYC);
    localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TIMEOUT);
    localparam logic [BW-1:0] BYP_ONE  = BW'(1);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    typedef enum logic [2:0] {
        IDLE_BYP  = 3'd0,
        BYPASS    = 3'd1,
        APPLY     = 3'd2,
        WAIT_LOCK = 3'd3,
        LOCKED    = 3'd4,
        FAIL      = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [BW-1:0] byp_cnt, byp_nx;
    logic [SW-1:0] stab_cnt, stab_nx;
    logic [TW-1:0] to_cnt, to_nx;

    logic lock_sync_p0, lock_s;

    logic [5:0]  sh_refdiv;
    logic [11:0] sh_fbdiv;
    logic [2:0]  sh_postdiv1, sh_postdiv2;

    logic cfg_hs, cfg_legal;
    logic load_shadow, load_div, set_to, set_lost, clr_flags, err_nx;

    // Saturating increments: counters park at their terminal value, never wrap.
    function automatic logic [BW-1:0] sat_inc_byp(input logic [BW-1:0] v);
        return (v == BYP_MAX) ? v : v + BYP_ONE;
    endfunction

    function automatic logic [SW-1:0] sat_inc_stab(input logic [SW-1:0] v);
        return (v == STAB_MAX) ? v : v + STAB_ONE;
    endfunction

    function automatic logic [TW-1:0] sat_inc_to(input logic [TW-1:0] v);
        return (v == TO_MAX) ? v : v + TO_ONE;
    endfunction

    assign cfg_hs    = cfg_valid_i & cfg_ready_o;
    assign cfg_legal = (cfg_refdiv_i != 6'd0) && (cfg_fbdiv_i >= 12'd16) &&
                       (cfg_postdiv1_i != 3'd0) && (cfg_postdiv2_i != 3'd0) &&
                       (cfg_postdiv2_i <= cfg_postdiv1_i);

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_sync_p0 <= 1'b0;
            lock_s       <= 1'b0;
        end else begin
            lock_sync_p0 <= pll_lock_i;
            lock_s       <= lock_sync_p0;
        end
    end

    // Next-state, counter and event decode; an accepted handshake overrides
    // whatever the current state would otherwise do (including lock loss).
    always_comb begin
        state_nx    = state;
        byp_nx      = byp_cnt;
        stab_nx     = stab_cnt;
        to_nx       = to_cnt;
        load_shadow = 1'b0;
        load_div    = 1'b0;
        set_to      = 1'b0;
        set_lost    = 1'b0;
        clr_flags   = 1'b0;
        err_nx      = cfg_hs & ~cfg_legal;

        if (cfg_hs && cfg_legal) begin
            load_shadow = 1'b1;
            clr_flags   = 1'b1;
            byp_nx      = '0;
            state_nx    = BYPASS;
        end else begin
            unique case (state)
                BYPASS: begin
                    byp_nx = sat_inc_byp(byp_cnt);
                    if (byp_nx == BYP_MAX) state_nx = APPLY;
                end
                APPLY: begin
                    load_div = 1'b1;
                    stab_nx  = '0;
                    to_nx    = '0;
                    state_nx = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    stab_nx = lock_s ? sat_inc_stab(stab_cnt) : '0;
                    to_nx   = sat_inc_to(to_cnt);
                    if (stab_nx == STAB_MAX) begin
                        state_nx = LOCKED;
                    end else if (to_nx == TO_MAX) begin
                        state_nx = FAIL;
                        set_to   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!lock_s) begin
                        set_lost = 1'b1;
                        stab_nx  = '0;
                        to_nx    = '0;
                        state_nx = WAIT_LOCK;
                    end
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: begin
                    state_nx = WAIT_LOCK;
                end
            endcase
        end
    end

    // State and counter registers; reset re-waits for lock on the defaults.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= WAIT_LOCK;
            byp_cnt  <= '0;
            stab_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nx;
            byp_cnt  <= byp_nx;
            stab_cnt <= stab_nx;
            to_cnt   <= to_nx;
        end
    end

    // Shadow copy of the accepted configuration, and the PLL-facing dividers
    // that only pick it up when leaving APPLY.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_refdiv   <= DEF_REFDIV;
            sh_fbdiv    <= DEF_FBDIV;
            sh_postdiv1 <= DEF_POSTDIV1;
            sh_postdiv2 <= DEF_POSTDIV2;
            refdiv_o    <= DEF_REFDIV;
            fbdiv_o     <= DEF_FBDIV;
            postdiv1_o  <= DEF_POSTDIV1;
            postdiv2_o  <= DEF_POSTDIV2;
        end else begin
            if (load_shadow) begin
                sh_refdiv   <= cfg_refdiv_i;
                sh_fbdiv    <= cfg_fbdiv_i;
                sh_postdiv1 <= cfg_postdiv1_i;
                sh_postdiv2 <= cfg_postdiv2_i;
            end
            if (load_div) begin
                refdiv_o   <= sh_refdiv;
                fbdiv_o    <= sh_fbdiv;
                postdiv1_o <= sh_postdiv1;
                postdiv2_o <= sh_postdiv2;
            end
        end
    end

    // Registered status outputs, decoded from the next state so they line up
    // with the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_ready_o <= 1'b0;
            bypass_o    <= 1'b1;
            locked_o    <= 1'b0;
            err_cfg_o   <= 1'b0;
            timeout_o   <= 1'b0;
            lock_lost_o <= 1'b0;
        end else begin
            cfg_ready_o <= (state_nx == LOCKED) || (state_nx == FAIL);
            bypass_o    <= (state_nx != LOCKED);
            locked_o    <= (state_nx == LOCKED);
            err_cfg_o   <= err_nx;
            if (clr_flags) begin
                timeout_o   <= 1'b0;
                lock_lost_o <= 1'b0;
            end else begin
                if (set_to)   timeout_o   <= 1'b1;
                if (set_lost) lock_lost_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// Bench for pll_cfg_ctrl: directed scenarios plus random traffic, checked
// every cycle against a timestamp/countdown style behavioural model.
module tb_pll_cfg_ctrl;

    localparam int BYPASS_CYC   = 4;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [5:0]  cfg_refdiv = 6'd1;
    logic [11:0] cfg_fbdiv = 12'd16;
    logic [2:0]  cfg_pd1 = 3'd1;
    logic [2:0]  cfg_pd2 = 3'd1;
    logic        pll_lock = 1'b0;

    logic        cfg_ready;
    logic [5:0]  refdiv;
    logic [11:0] fbdiv;
    logic [2:0]  pd1, pd2;
    logic        bypass, locked, err_cfg, timeout, lock_lost;

    pll_cfg_ctrl #(
        .DEF_REFDIV(6'd1), .DEF_FBDIV(12'd16), .DEF_POSTDIV1(3'd1), .DEF_POSTDIV2(3'd1),
        .BYPASS_CYC(BYPASS_CYC), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_refdiv_i(cfg_refdiv), .cfg_fbdiv_i(cfg_fbdiv),
        .cfg_postdiv1_i(cfg_pd1), .cfg_postdiv2_i(cfg_pd2),
        .refdiv_o(refdiv), .fbdiv_o(fbdiv), .postdiv1_o(pd1), .postdiv2_o(pd2),
        .pll_lock_i(pll_lock), .bypass_o(bypass), .locked_o(locked),
        .err_cfg_o(err_cfg), .timeout_o(timeout), .lock_lost_o(lock_lost)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: waiting for lock, running, dead (timed out), switching (bypass
    // plus apply, expressed as a countdown to the divider load).
    typedef enum int {M_WAIT, M_RUN, M_DEAD, M_SWITCH} mmode_t;
    mmode_t m_mode = M_WAIT;
    int m_left = 0, m_run = 0, m_waited = 0;
    logic m_s1 = 1'b0, m_s2 = 1'b0;   // lock as seen one and two edges late
    logic [5:0]  e_refdiv = 6'd1, sh_refdiv = 6'd1;
    logic [11:0] e_fbdiv = 12'd16, sh_fbdiv = 12'd16;
    logic [2:0]  e_pd1 = 3'd1, sh_pd1 = 3'd1, e_pd2 = 3'd1, sh_pd2 = 3'd1;
    logic e_err = 1'b0, e_to = 1'b0, e_lost = 1'b0;

    function automatic logic legal(input logic [5:0] r, input logic [11:0] f,
                                   input logic [2:0] a, input logic [2:0] b);
        return !(r == 0 || f < 16 || a == 0 || b == 0 || b > a);
    endfunction

    task automatic m_reset();
        m_mode = M_WAIT; m_left = 0; m_run = 0; m_waited = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
        e_refdiv = 6'd1; e_fbdiv = 12'd16; e_pd1 = 3'd1; e_pd2 = 3'd1;
        sh_refdiv = 6'd1; sh_fbdiv = 12'd16; sh_pd1 = 3'd1; sh_pd2 = 3'd1;
        e_err = 1'b0; e_to = 1'b0; e_lost = 1'b0;
    endtask

    task automatic m_step();
        logic ls, hs, ok;
        ls = m_s2;
        hs = ((m_mode == M_RUN) || (m_mode == M_DEAD)) && (cfg_valid === 1'b1);
        ok = legal(cfg_refdiv, cfg_fbdiv, cfg_pd1, cfg_pd2);
        e_err = hs && !ok;
        if (hs && ok) begin
            sh_refdiv = cfg_refdiv; sh_fbdiv = cfg_fbdiv; sh_pd1 = cfg_pd1; sh_pd2 = cfg_pd2;
            e_to = 1'b0; e_lost = 1'b0;
            m_mode = M_SWITCH;
            m_left = BYPASS_CYC + 1;
        end else begin
            case (m_mode)
                M_SWITCH: begin
                    m_left--;
                    if (m_left == 0) begin
                        e_refdiv = sh_refdiv; e_fbdiv = sh_fbdiv; e_pd1 = sh_pd1; e_pd2 = sh_pd2;
                        m_mode = M_WAIT; m_run = 0; m_waited = 0;
                    end
                end
                M_WAIT: begin
                    m_run = ls ? m_run + 1 : 0;
                    m_waited++;
                    if (m_run >= LOCK_STABLE) m_mode = M_RUN;
                    else if (m_waited >= LOCK_TIMEOUT) begin
                        m_mode = M_DEAD;
                        e_to = 1'b1;
                    end
                end
                M_RUN: begin
                    if (!ls) begin
                        e_lost = 1'b1;
                        m_mode = M_WAIT; m_run = 0; m_waited = 0;
                    end
                end
                default: ;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = pll_lock;
    endtask

    task automatic check_all();
        logic e_ready, e_byp, e_lock;
        e_ready = (m_mode == M_RUN) || (m_mode == M_DEAD);
        e_byp   = (m_mode != M_RUN);
        e_lock  = (m_mode == M_RUN);
        chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
        chk("bypass",    32'(bypass),    32'(e_byp));
        chk("locked",    32'(locked),    32'(e_lock));
        chk("err_cfg",   32'(err_cfg),   32'(e_err));
        chk("timeout",   32'(timeout),   32'(e_to));
        chk("lock_lost", 32'(lock_lost), 32'(e_lost));
        chk("refdiv",    32'(refdiv),    32'(e_refdiv));
        chk("fbdiv",     32'(fbdiv),     32'(e_fbdiv));
        chk("postdiv1",  32'(pd1),       32'(e_pd1));
        chk("postdiv2",  32'(pd2),       32'(e_pd2));
    endtask

    // Single compare process: advance the model on every edge / reset, then
    // compare all outputs 1 ns later.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) m_reset();
        else        m_step();
        #1;
        check_all();
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [5:0] r, input logic [11:0] f,
                         input logic [2:0] a, input logic [2:0] b);
        cfg_valid = 1'b1; cfg_refdiv = r; cfg_fbdiv = f; cfg_pd1 = a; cfg_pd2 = b;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_fbdiv(input logic [11:0] v, input string nm);
        int k;
        k = 0;
        while (fbdiv !== v && k < 40) begin cyc(1); k++; end
        chk(nm, 32'(k < 40), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int kbyp, k, seen;
        logic [2:0] a;

        // 1: reset with lock held high, default dividers
        pll_lock = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("rst_bypass", 32'(bypass), 32'd1);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cyc(17);
        chk("t1_locked_pre", 32'(locked), 32'd0);
        cyc(1);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_model_locked", 32'(m_mode == M_RUN), 32'd1);
        chk("t1_bypass", 32'(bypass), 32'd0);
        chk("t1_div", {8'd0, 6'(refdiv), 12'(fbdiv), 3'(pd1), 3'(pd2)},
            {8'd0, 6'd1, 12'd16, 3'd1, 3'd1});

        // 2: legal reconfiguration while locked
        offer(6'd2, 12'd100, 3'd4, 3'd2);
        chk("t2_bypass", 32'(bypass), 32'd1);
        chk("t2_ready", 32'(cfg_ready), 32'd0);
        kbyp = 0; k = 0;
        while (fbdiv !== 12'd100 && k < 20) begin
            if (bypass === 1'b1) kbyp++;
            cyc(1); k++;
        end
        chk("t2_byp_cycles", 32'(kbyp), 32'd5);
        chk("t2_refdiv", 32'(refdiv), 32'd2);
        chk("t2_pd", 32'({pd1, pd2}), 32'({3'd4, 3'd2}));
        cyc(15);
        chk("t2_relock_pre", 32'(locked), 32'd0);
        cyc(1);
        chk("t2_relock", 32'(locked), 32'd1);

        // 3: illegal configurations are consumed with an error pulse
        offer(6'd0, 12'd100, 3'd4, 3'd2);
        chk("t3a_err", 32'(err_cfg), 32'd1);
        chk("t3a_locked", 32'(locked), 32'd1);
        cyc(1);
        chk("t3a_err_end", 32'(err_cfg), 32'd0);
        offer(6'd2, 12'd8, 3'd4, 3'd2);
        chk("t3b_err", 32'(err_cfg), 32'd1);
        cyc(1);
        offer(6'd2, 12'd100, 3'd2, 3'd3);
        chk("t3c_err", 32'(err_cfg), 32'd1);
        chk("t3c_fbdiv", 32'(fbdiv), 32'd100);
        cyc(1);
        chk("t3c_locked", 32'(locked), 32'd1);

        // 6b + 4: handshake in the cycle lock loss is seen, then timeout
        pll_lock = 1'b0;
        cyc(2);
        offer(6'd3, 12'd50, 3'd3, 3'd1);
        chk("t6b_lost", 32'(lock_lost), 32'd0);
        chk("t6b_bypass", 32'(bypass), 32'd1);
        wait_fbdiv(12'd50, "t4_apply_wait");
        cyc(4095);
        chk("t4_timeout_pre", 32'(timeout), 32'd0);
        cyc(1);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_model_timeout", 32'(e_to), 32'd1);
        chk("t4_ready", 32'(cfg_ready), 32'd1);
        chk("t4_fbdiv_kept", 32'(fbdiv), 32'd50);
        offer(6'd1, 12'd32, 3'd2, 3'd2);
        chk("t4_timeout_clr", 32'(timeout), 32'd0);

        // 5: lock toggling every 10 cycles never debounces
        wait_fbdiv(12'd32, "t5_apply_wait");
        seen = 0;
        for (int i = 0; i < 4200; i++) begin
            if (i % 10 == 0) pll_lock = ~pll_lock;
            cyc(1);
            if (locked === 1'b1) seen++;
        end
        chk("t5_never_locked", 32'(seen), 32'd0);
        chk("t5_timeout", 32'(timeout), 32'd1);

        // 6: lock loss in LOCKED, then relock keeping the sticky flag
        pll_lock = 1'b1;
        offer(6'd1, 12'd40, 3'd2, 3'd1);
        k = 0;
        while (locked !== 1'b1 && k < 60) begin cyc(1); k++; end
        chk("t6_lock_wait", 32'(k < 60), 32'd1);
        pll_lock = 1'b0;
        cyc(3);
        chk("t6_lost", 32'(lock_lost), 32'd1);
        chk("t6_bypass", 32'(bypass), 32'd1);
        chk("t6_locked", 32'(locked), 32'd0);
        pll_lock = 1'b1;
        cyc(17);
        chk("t6_relock_pre", 32'(locked), 32'd0);
        cyc(1);
        chk("t6_relock", 32'(locked), 32'd1);
        chk("t6_lost_sticky", 32'(lock_lost), 32'd1);

        // 7: asynchronous reset in the middle of a bypass sequence
        offer(6'd5, 12'd200, 3'd4, 3'd4);
        cyc(2);
        #2 rst_n = 1'b0;
        #1 chk("t7_fbdiv", 32'(fbdiv), 32'd16);
        chk("t7_bypass", 32'(bypass), 32'd1);
        chk("t7_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(18);
        chk("t7_relock", 32'(locked), 32'd1);
        chk("t7_def_fbdiv", 32'(fbdiv), 32'd16);

        // 8: random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
            cfg_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) begin
                a = 3'($urandom_range(1, 7));
                cfg_refdiv = 6'($urandom_range(1, 63));
                cfg_fbdiv  = 12'($urandom_range(16, 4095));
                cfg_pd1    = a;
                cfg_pd2    = 3'($urandom_range(1, 32'(a)));
            end else begin
                cfg_refdiv = 6'($urandom);
                cfg_fbdiv  = 12'($urandom_range(0, 31));
                cfg_pd1    = 3'($urandom);
                cfg_pd2    = 3'($urandom);
            end
            cyc(1);
        end
        cfg_valid = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
